// File: rtl/ysyx_24110006_axi_arbiter_pkg.sv
// ysyx_24110006_axi_arbiter_pkg: shared AXI widths, master indices and FSM state encoding
// Ports: none (package only).
package ysyx_24110006_axi_arbiter_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int STRB_W  = 4;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } state_t;
endpackage

// File: rtl/ysyx_24110006_axi_arbiter_if.sv
// ysyx_24110006_axi_arbiter_if: one AXI4 port (AR, R, AW, W, B channels)
// Modports: master (drives requests), slave (answers requests),
//           rd_slave (read-only slave view used for the instruction fetch port).
interface ysyx_24110006_axi_arbiter_if;
    import ysyx_24110006_axi_arbiter_pkg::*;

    logic [ADDR_W-1:0]  araddr;
    logic               arvalid;
    logic               arready;
    logic [ID_W-1:0]    arid;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;

    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic [ID_W-1:0]    rid;
    logic               rvalid;
    logic               rready;

    logic [ADDR_W-1:0]  awaddr;
    logic               awvalid;
    logic               awready;
    logic [ID_W-1:0]    awid;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;

    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;

    logic [RESP_W-1:0]  bresp;
    logic [ID_W-1:0]    bid;
    logic               bvalid;
    logic               bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, input arready,
        input rdata, rresp, rlast, rid, rvalid, output rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bid, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, arid, arlen, arsize, arburst, output arready,
        output rdata, rresp, rlast, rid, rvalid, input rready,
        input awaddr, awvalid, awid, awlen, awsize, awburst, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bid, bvalid, input bready
    );

    modport rd_slave (
        input araddr, arvalid, arid, arlen, arsize, arburst, output arready,
        output rdata, rresp, rlast, rid, rvalid, input rready
    );
endinterface

// File: rtl/ysyx_24110006_rr_pick.sv
// ysyx_24110006_rr_pick: combinational 2-way round-robin pick
// Ports: req0/req1 requests, last_grant previously served master, pick chosen master index.
module ysyx_24110006_rr_pick
    import ysyx_24110006_axi_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic pick
);
    // On a tie the master not served last wins; otherwise the lone requester.
    assign pick = (req0 && req1) ? ~last_grant : (req1 ? M_LSU : M_IFU);
endmodule

// File: rtl/ysyx_24110006_axi_arbiter.sv
// ysyx_24110006_axi_arbiter: two-master one-slave AXI4 arbiter, one transaction at a time
// Ports: i_clock, i_reset_n (sync, active-low), m0 (IFU, read-only), m1 (LSU, read/write),
//        s (shared slave port), o_busy (high while a transaction is granted).
module ysyx_24110006_axi_arbiter
    import ysyx_24110006_axi_arbiter_pkg::*;
(
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    ysyx_24110006_axi_arbiter_if.rd_slave        m0,
    ysyx_24110006_axi_arbiter_if.slave           m1,
    ysyx_24110006_axi_arbiter_if.master          s,
    output logic                                 o_busy
);
    state_t state;
    logic   last_grant;
    logic   pick;
    logic   rd0, rd1, wr1, m1_req, r_done, b_done;

    assign rd0    = state == RD0;
    assign rd1    = state == RD1;
    assign wr1    = state == WR1;
    assign m1_req = m1.arvalid || m1.awvalid;
    assign r_done = s.rvalid && s.rready && s.rlast;
    assign b_done = s.bvalid && s.bready;

    ysyx_24110006_rr_pick u_pick (
        .req0       (m0.arvalid),
        .req1       (m1_req),
        .last_grant (last_grant),
        .pick       (pick)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            last_grant <= M_IFU;
            o_busy     <= 1'b0;
        end else if (state == IDLE) begin
            if (m0.arvalid || m1_req) begin
                // An LSU that raises both AR and AW is served as a read first.
                state      <= (pick == M_IFU) ? RD0 : (m1.arvalid ? RD1 : WR1);
                last_grant <= pick;
                o_busy     <= 1'b1;
            end
        end else if (((rd0 || rd1) && r_done) || (wr1 && b_done)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end
    end

    // Slave-side AR / R
    assign s.araddr  = rd0 ? m0.araddr  : (rd1 ? m1.araddr  : '0);
    assign s.arid    = rd0 ? m0.arid    : (rd1 ? m1.arid    : '0);
    assign s.arlen   = rd0 ? m0.arlen   : (rd1 ? m1.arlen   : '0);
    assign s.arsize  = rd0 ? m0.arsize  : (rd1 ? m1.arsize  : '0);
    assign s.arburst = rd0 ? m0.arburst : (rd1 ? m1.arburst : '0);
    assign s.arvalid = (rd0 && m0.arvalid) || (rd1 && m1.arvalid);
    assign s.rready  = (rd0 && m0.rready)  || (rd1 && m1.rready);

    // Slave-side AW / W / B
    assign s.awaddr  = wr1 ? m1.awaddr  : '0;
    assign s.awid    = wr1 ? m1.awid    : '0;
    assign s.awlen   = wr1 ? m1.awlen   : '0;
    assign s.awsize  = wr1 ? m1.awsize  : '0;
    assign s.awburst = wr1 ? m1.awburst : '0;
    assign s.awvalid = wr1 && m1.awvalid;
    assign s.wdata   = wr1 ? m1.wdata   : '0;
    assign s.wstrb   = wr1 ? m1.wstrb   : '0;
    assign s.wlast   = wr1 && m1.wlast;
    assign s.wvalid  = wr1 && m1.wvalid;
    assign s.bready  = wr1 && m1.bready;

    // IFU return path
    assign m0.arready = rd0 && s.arready;
    assign m0.rvalid  = rd0 && s.rvalid;
    assign m0.rdata   = rd0 ? s.rdata : '0;
    assign m0.rresp   = rd0 ? s.rresp : '0;
    assign m0.rlast   = rd0 && s.rlast;
    assign m0.rid     = rd0 ? s.rid   : '0;

    // LSU return path
    assign m1.arready = rd1 && s.arready;
    assign m1.rvalid  = rd1 && s.rvalid;
    assign m1.rdata   = rd1 ? s.rdata : '0;
    assign m1.rresp   = rd1 ? s.rresp : '0;
    assign m1.rlast   = rd1 && s.rlast;
    assign m1.rid     = rd1 ? s.rid   : '0;
    assign m1.awready = wr1 && s.awready;
    assign m1.wready  = wr1 && s.wready;
    assign m1.bvalid  = wr1 && s.bvalid;
    assign m1.bresp   = wr1 ? s.bresp : '0;
    assign m1.bid     = wr1 ? s.bid   : '0;
endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// tb_ysyx_24110006_axi_arbiter: self-checking bench for the two-master AXI arbiter
module tb_ysyx_24110006_axi_arbiter;
    import ysyx_24110006_axi_arbiter_pkg::*;

    logic i_clock   = 1'b0;
    logic i_reset_n = 1'b0;
    logic o_busy;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hist[$];

    ysyx_24110006_axi_arbiter_if m0_bus ();
    ysyx_24110006_axi_arbiter_if m1_bus ();
    ysyx_24110006_axi_arbiter_if s_bus ();

    ysyx_24110006_axi_arbiter dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .o_busy    (o_busy)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        r0, r1, w1;
        logic [31:0] ar, aw;
    } vec_t;

    vec_t tv[8];

    task automatic tick;
        @(posedge i_clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_masters;
        m0_bus.araddr = '0; m0_bus.arvalid = 0; m0_bus.arid = 4'h3; m0_bus.arlen = '0;
        m0_bus.arsize = 3'd2; m0_bus.arburst = 2'b01; m0_bus.rready = 0;
        m1_bus.araddr = '0; m1_bus.arvalid = 0; m1_bus.arid = 4'h5; m1_bus.arlen = '0;
        m1_bus.arsize = 3'd2; m1_bus.arburst = 2'b01; m1_bus.rready = 0;
        m1_bus.awaddr = '0; m1_bus.awvalid = 0; m1_bus.awid = 4'h6; m1_bus.awlen = '0;
        m1_bus.awsize = 3'd2; m1_bus.awburst = 2'b01;
        m1_bus.wdata = '0; m1_bus.wstrb = '0; m1_bus.wlast = 0; m1_bus.wvalid = 0; m1_bus.bready = 0;
    endtask

    task automatic clr_slave;
        s_bus.arready = 0; s_bus.rdata = '0; s_bus.rresp = '0; s_bus.rlast = 0; s_bus.rid = '0;
        s_bus.rvalid = 0; s_bus.awready = 0; s_bus.wready = 0; s_bus.bresp = '0; s_bus.bid = '0;
        s_bus.bvalid = 0;
    endtask

    task automatic do_reset;
        i_reset_n = 0;
        clr_masters;
        clr_slave;
        tick;
        i_reset_n = 1;
        hist.delete();
        #1;
        chk("reset_busy", o_busy, 0);
    endtask

    task automatic req_write(input logic [31:0] addr, input logic [31:0] data);
        m1_bus.awaddr = addr; m1_bus.awvalid = 1;
        m1_bus.wdata = data; m1_bus.wstrb = 4'hF; m1_bus.wlast = 1; m1_bus.wvalid = 1;
    endtask

    // Acts as the slave for one read granted to master m; checks routing beat by beat.
    task automatic do_read(input int m, input logic [31:0] addr, input int beats,
                           input logic [1:0] resp, input int stall);
        int t = 0;
        #1;
        while (!s_bus.arvalid && t < 16) begin tick; #1; t++; end
        chk("ar_grant", s_bus.arvalid, 1);
        chk("araddr", s_bus.araddr, addr);
        chk("arid", s_bus.arid, (m != 0) ? 5 : 3);
        chk("wr_quiet_in_rd", s_bus.awvalid | s_bus.wvalid, 0);
        s_bus.arready = 1;
        #1;
        chk("arready", (m != 0) ? m1_bus.arready : m0_bus.arready, 1);
        chk("arready_other", (m != 0) ? m0_bus.arready : m1_bus.arready, 0);
        tick;
        if (m != 0) m1_bus.arvalid = 0; else m0_bus.arvalid = 0;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_busy", o_busy, 1);
            chk("stall_other_arready", (m != 0) ? m0_bus.arready : m1_bus.arready, 0);
            tick;
        end
        s_bus.arready = 0;
        if (m != 0) m1_bus.rready = 1; else m0_bus.rready = 1;
        for (int b = 0; b < beats; b++) begin
            s_bus.rvalid = 1; s_bus.rdata = addr + b; s_bus.rresp = resp;
            s_bus.rlast = (b == beats - 1); s_bus.rid = 4'hA;
            #1;
            chk("rvalid", (m != 0) ? m1_bus.rvalid : m0_bus.rvalid, 1);
            chk("rdata", (m != 0) ? m1_bus.rdata : m0_bus.rdata, addr + b);
            chk("rresp", (m != 0) ? m1_bus.rresp : m0_bus.rresp, resp);
            chk("rlast", (m != 0) ? m1_bus.rlast : m0_bus.rlast, b == beats - 1);
            chk("rid", (m != 0) ? m1_bus.rid : m0_bus.rid, 4'hA);
            chk("rvalid_other", (m != 0) ? m0_bus.rvalid : m1_bus.rvalid, 0);
            chk("busy_rd", o_busy, 1);
            tick;
        end
        #1;
        chk("busy_after_r", o_busy, 0);
        chk("rvalid_after_r", (m != 0) ? m1_bus.rvalid : m0_bus.rvalid, 0);
        clr_slave;
        m0_bus.rready = 0; m1_bus.rready = 0;
    endtask

    // Acts as the slave for one m1 write; W accepted at cycle wcyc, AW at awcyc after grant.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int wcyc, input int awcyc, input logic [1:0] resp);
        int t = 0;
        int last = (wcyc > awcyc) ? wcyc : awcyc;
        #1;
        while (!(s_bus.awvalid || s_bus.wvalid) && t < 16) begin tick; #1; t++; end
        chk("wr_grant", s_bus.awvalid, 1);
        chk("rd_quiet_in_wr", s_bus.arvalid, 0);
        for (int c = 0; c <= last; c++) begin
            s_bus.wready = (c == wcyc); s_bus.awready = (c == awcyc);
            #1;
            if (c == wcyc) begin
                chk("wdata", s_bus.wdata, data);
                chk("wstrb", s_bus.wstrb, 4'hF);
                chk("wready", m1_bus.wready, 1);
            end
            if (c == awcyc) begin
                chk("awaddr", s_bus.awaddr, addr);
                chk("awready", m1_bus.awready, 1);
            end
            chk("m0_arready_in_wr", m0_bus.arready, 0);
            tick;
            if (c == wcyc) m1_bus.wvalid = 0;
            if (c == awcyc) m1_bus.awvalid = 0;
        end
        s_bus.wready = 0; s_bus.awready = 0;
        s_bus.bvalid = 1; s_bus.bresp = resp; s_bus.bid = 4'h6; m1_bus.bready = 1;
        #1;
        chk("bvalid", m1_bus.bvalid, 1);
        chk("bresp", m1_bus.bresp, resp);
        chk("bid", m1_bus.bid, 4'h6);
        chk("m0_rvalid_in_wr", m0_bus.rvalid, 0);
        chk("busy_wr", o_busy, 1);
        tick;
        #1;
        chk("busy_after_b", o_busy, 0);
        chk("bvalid_after_b", m1_bus.bvalid, 0);
        clr_slave;
        m1_bus.bready = 0;
    endtask

    initial begin
        logic        r0, r1, w1;
        logic [31:0] a0, a1, aw, wd;
        int          win;

        tv[0] = '{1, 0, 0, 32'h100, 32'h0};
        tv[1] = '{0, 1, 0, 32'h200, 32'h0};
        tv[2] = '{0, 0, 1, 32'h0,   32'h300};
        tv[3] = '{0, 1, 1, 32'h200, 32'h0};
        tv[4] = '{1, 1, 0, 32'h200, 32'h0};
        tv[5] = '{1, 0, 1, 32'h0,   32'h300};
        tv[6] = '{1, 1, 1, 32'h200, 32'h0};
        tv[7] = '{0, 0, 0, 32'h0,   32'h0};

        // First decision out of reset for every request mix
        foreach (tv[i]) begin
            do_reset;
            m0_bus.arvalid = tv[i].r0; m0_bus.araddr = 32'h100;
            m1_bus.arvalid = tv[i].r1; m1_bus.araddr = 32'h200;
            if (tv[i].w1) req_write(32'h300, 32'h1234_5678);
            #1;
            chk("tbl_pre_valid", s_bus.arvalid | s_bus.awvalid, 0);
            tick;
            #1;
            chk("tbl_arvalid", s_bus.arvalid, tv[i].ar != 0);
            chk("tbl_araddr", s_bus.araddr, tv[i].ar);
            chk("tbl_awvalid", s_bus.awvalid, tv[i].aw != 0);
            chk("tbl_awaddr", s_bus.awaddr, tv[i].aw);
            chk("tbl_wvalid", s_bus.wvalid, tv[i].aw != 0);
            chk("tbl_busy", o_busy, (tv[i].ar | tv[i].aw) != 0);
        end

        // IFU read alone
        do_reset;
        m0_bus.araddr = 32'h8000_0000; m0_bus.arvalid = 1;
        #1;
        chk("ifu_pre_arvalid", s_bus.arvalid, 0);
        tick;
        #1;
        chk("ifu_arvalid_n1", s_bus.arvalid, 1);
        s_bus.arready = 1;
        tick;
        m0_bus.arvalid = 0; s_bus.arready = 0; m0_bus.rready = 1;
        s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0413; s_bus.rlast = 1; s_bus.rid = 4'h3;
        #1;
        chk("ifu_rdata", m0_bus.rdata, 32'h0000_0413);
        chk("ifu_m1_rvalid", m1_bus.rvalid, 0);
        chk("ifu_busy", o_busy, 1);
        tick;
        #1;
        chk("ifu_idle_after", o_busy, 0);
        clr_slave; clr_masters;

        // Tie straight after reset: m1 first, then m0 on the next idle cycle
        do_reset;
        m0_bus.arvalid = 1; m0_bus.araddr = 32'h8000_0010;
        m1_bus.arvalid = 1; m1_bus.araddr = 32'h8000_0020;
        do_read(1, 32'h8000_0020, 1, 2'b00, 0);
        chk("tie_idle_gap", s_bus.arvalid, 0);
        do_read(0, 32'h8000_0010, 1, 2'b00, 0);
        clr_masters;
        tick;

        // LSU write with W two cycles before AW while IFU waits
        do_reset;
        m0_bus.arvalid = 1; m0_bus.araddr = 32'h8000_0200;
        req_write(32'h8000_0100, 32'hDEAD_BEEF);
        do_write(32'h8000_0100, 32'hDEAD_BEEF, 0, 2, 2'b00);
        do_read(0, 32'h8000_0200, 1, 2'b00, 0);
        clr_masters;
        tick;

        // Slave stalls R for 5 cycles while m1 waits; m1 served next
        do_reset;
        m1_bus.arvalid = 1; m1_bus.araddr = 32'h8000_0300;
        do_read(1, 32'h8000_0300, 1, 2'b00, 0);
        m0_bus.arvalid = 1; m0_bus.araddr = 32'h8000_0400;
        m1_bus.arvalid = 1; m1_bus.araddr = 32'h8000_0500;
        tick;
        do_read(0, 32'h8000_0400, 2, 2'b00, 5);
        do_read(1, 32'h8000_0500, 1, 2'b10, 0);
        clr_masters;
        tick;

        // Reset in the middle of an IFU burst
        do_reset;
        m0_bus.araddr = 32'h8000_0040; m0_bus.arlen = 8'd3; m0_bus.arvalid = 1;
        tick;
        s_bus.arready = 1;
        tick;
        m0_bus.arvalid = 0; s_bus.arready = 0; m0_bus.rready = 1;
        s_bus.rvalid = 1; s_bus.rdata = 32'h1111_0000; s_bus.rlast = 0;
        tick;
        i_reset_n = 0;
        tick;
        i_reset_n = 1;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_s_rready", s_bus.rready, 0);
        chk("rst_m0_rvalid", m0_bus.rvalid, 0);
        chk("rst_s_arvalid", s_bus.arvalid, 0);
        clr_slave; clr_masters;
        m0_bus.arvalid = 1; m0_bus.araddr = 32'h8000_0050;
        m1_bus.arvalid = 1; m1_bus.araddr = 32'h8000_0060;
        do_read(1, 32'h8000_0060, 1, 2'b00, 0);
        clr_masters;
        tick;

        // Randomized rounds against a round-robin model built on the grant history
        do_reset;
        for (int k = 0; k < 40; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            if (!(r0 || r1 || w1)) r0 = 1;
            a0 = $urandom & 32'hFFFF_FFF0;
            a1 = $urandom & 32'hFFFF_FFF0;
            aw = $urandom & 32'hFFFF_FFF0;
            wd = $urandom;
            m0_bus.arvalid = r0; m0_bus.araddr = a0;
            m1_bus.arvalid = r1; m1_bus.araddr = a1;
            if (w1) req_write(aw, wd);
            if (r0 && (r1 || w1)) win = (hist.size() == 0 || hist[$] == 0) ? 1 : 0;
            else win = (r1 || w1) ? 1 : 0;
            hist.push_back(win);
            if (win == 0)
                do_read(0, a0, $urandom_range(1, 4), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
            else if (r1)
                do_read(1, a1, $urandom_range(1, 4), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
            else
                do_write(aw, wd, $urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom_range(0, 3)));
            clr_masters;
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
